sort_seq_ctrl: RTL and testbench

//  Sorts a block of DEPTH unsigned words in ascending order using one 2-input compare-swap unit.
//  - Unit behaviour: max -> G, min -> L.
//  - Flow: LOAD accepts a block on a valid/ready stream, SORT runs a fixed-schedule bubble sort,

---
 rtl/sort_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_sort_seq_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sort_seq_ctrl.sv
// Block sorter: loads DEPTH words, bubble-sorts them with a single compare-swap
// unit on a fixed schedule, then streams them out smallest first.

module sort_cmp_swap #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  // Equal operands fall through unswapped.
  assign lo = (a > b) ? b : a;
  assign hi = (a > b) ? a : b;
endmodule

module sort_seq_ctrl #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = AW + 1;
  localparam logic [IW-1:0] LAST  = IW'(DEPTH - 1);
  localparam logic [IW-1:0] LPASS = IW'(DEPTH - 2);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t state, state_nxt;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [IW-1:0]    wr_idx, pass, j, rd_idx;
  logic [IW-1:0]    j1, rd_nxt;
  logic [WIDTH-1:0] cs_a, cs_b, cs_lo, cs_hi;
  logic             in_fire, out_fire, wr_last, pass_end, sort_done;

  assign j1     = j + 1'b1;
  assign rd_nxt = rd_idx + 1'b1;
  assign cs_a   = mem[j[AW-1:0]];
  assign cs_b   = mem[j1[AW-1:0]];

  sort_cmp_swap #(.WIDTH(WIDTH)) u_cs (.a(cs_a), .b(cs_b), .lo(cs_lo), .hi(cs_hi));

  assign wr_last   = (wr_idx == LAST);
  assign pass_end  = (j == LPASS - pass);
  // Final pass has a single pair at j=0.
  assign sort_done = pass_end && (pass == LPASS);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && wr_last) state_nxt = SORT;
      end
      SORT: begin
        busy = 1'b1;
        if (sort_done) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready && rd_idx == LAST) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  assign out_last = out_valid && (rd_idx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem      <= '0;
      wr_idx   <= '0;
      pass     <= '0;
      j        <= '0;
      rd_idx   <= '0;
      out_data <= '0;
    end else begin
      case (state)
        LOAD: if (in_fire) begin
          mem[wr_idx[AW-1:0]] <= in_data;
          wr_idx <= wr_last ? '0 : wr_idx + 1'b1;
        end
        SORT: begin
          mem[j[AW-1:0]]  <= cs_lo;
          mem[j1[AW-1:0]] <= cs_hi;
          if (pass_end) begin
            j    <= '0;
            pass <= sort_done ? '0 : pass + 1'b1;
          end else begin
            j <= j1;
          end
          // Preload the output register with the smallest word so DRAIN starts valid.
          if (sort_done) out_data <= cs_lo;
        end
        DRAIN: if (out_fire) begin
          if (rd_idx == LAST) begin
            rd_idx   <= '0;
            out_data <= '0;
          end else begin
            rd_idx   <= rd_nxt;
            out_data <= mem[rd_nxt[AW-1:0]];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Directed bench for sort_seq_ctrl: hand-computed sorted blocks, latency,
// stall behaviour, ignored inputs and mid-sort reset.

module tb_sort_seq_ctrl;
  typedef logic [4:0] blk_t [8];

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready;
  logic [4:0] in_data;
  logic       in_ready, out_valid, out_last, busy;
  logic [4:0] out_data;

  int n_chk = 0;
  int n_fail = 0;

  sort_seq_ctrl #(.WIDTH(5), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
  endtask

  // Load one block; gap_at >= 0 drops in_valid for 3 cycles before that word.
  task automatic load_block(input blk_t w, input int gap_at);
    for (int i = 0; i < 8; i++) begin
      if (i == gap_at) begin
        in_valid = 1'b0;
        repeat (3) step();
      end
      in_valid = 1'b1;
      in_data  = w[i];
      step();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Called right after the last accept; counts cycles to first out_valid.
  task automatic wait_sort(input string tag, input bit noise, output int lat, inout int low);
    lat = 0;
    if (noise) begin
      in_valid = 1'b1;
      in_data  = 5'd31;
    end
    chk({tag, "_busy_sort"}, busy, 1);
    while (!out_valid && lat < 100) begin
      if (!in_ready) low++;
      step();
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, lat, 28);
  endtask

  // stall=1 drives out_ready as 1,0,0,1,0,0,...
  task automatic drain(input string tag, input blk_t exp, input bit stall, inout int low);
    int idx = 0;
    int cyc = 0;
    while (idx < 8 && cyc < 200) begin
      out_ready = stall ? ((cyc % 3) == 0) : 1'b1;
      if (!in_ready) low++;
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_data"}, out_data, exp[idx]);
      chk({tag, "_last"}, out_last, (idx == 7));
      if (out_ready) idx++;
      step();
      cyc++;
    end
    out_ready = 1'b0;
    chk({tag, "_drained"}, idx, 8);
    if (!stall) chk({tag, "_drain_cycles"}, cyc, 8);
    else        chk({tag, "_drain_cycles"}, cyc, 22);
    check_idle({tag, "_after"});
  endtask

  initial begin
    int   lat, low;
    blk_t w, e;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) step();
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    step();
    check_idle("rst");
    chk("rst_out_data2", out_data, 0);

    // 1: reverse order, out_ready held high throughout
    w = '{8, 7, 6, 5, 4, 3, 2, 1};
    e = '{1, 2, 3, 4, 5, 6, 7, 8};
    out_ready = 1'b1;
    load_block(w, -1);
    low = 0;
    wait_sort("t1", 1'b0, lat, low);
    drain("t1", e, 1'b0, low);
    chk("t1_in_ready_low_cycles", low, 36);

    // 2: extremes and duplicates
    w = '{31, 0, 17, 17, 3, 31, 0, 9};
    e = '{0, 0, 3, 9, 17, 17, 31, 31};
    load_block(w, -1);
    low = 0;
    wait_sort("t2", 1'b0, lat, low);
    drain("t2", e, 1'b0, low);

    // 3: all equal
    w = '{12, 12, 12, 12, 12, 12, 12, 12};
    load_block(w, -1);
    low = 0;
    wait_sort("t3", 1'b0, lat, low);
    drain("t3", w, 1'b0, low);

    // 4: stalled drain
    w = '{20, 10, 30, 0, 25, 15, 5, 31};
    e = '{0, 5, 10, 15, 20, 25, 30, 31};
    load_block(w, -1);
    low = 0;
    wait_sort("t4", 1'b0, lat, low);
    drain("t4", e, 1'b1, low);

    // 5: gapped load, in_valid held high with 31 during SORT
    w = '{9, 4, 22, 4, 0, 13, 7, 1};
    e = '{0, 1, 4, 4, 7, 9, 13, 22};
    load_block(w, 4);
    low = 0;
    wait_sort("t5", 1'b1, lat, low);
    drain("t5", e, 1'b0, low);

    // 6: reset at SORT cycle 10, then a fresh block
    w = '{30, 29, 28, 27, 26, 25, 24, 23};
    load_block(w, -1);
    repeat (10) step();
    chk("t6_busy_pre", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy_in_rst", busy, 0);
    chk("t6_out_valid_in_rst", out_valid, 0);
    chk("t6_out_data_in_rst", out_data, 0);
    step();
    rst_n = 1'b1;
    step();
    check_idle("t6_post_rst");
    w = '{2, 1, 4, 3, 6, 5, 8, 7};
    e = '{1, 2, 3, 4, 5, 6, 7, 8};
    load_block(w, -1);
    low = 0;
    wait_sort("t6", 1'b0, lat, low);
    drain("t6", e, 1'b0, low);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
